six_bit_two_port_arbiter: RTL

Round-robin arbiter and sequencer for the shared 6-bit two-to-one mux datapath. Two requesters compete for one 6-bit output channel. The block owns the mux select, grants one requester at a time for a bounded burst, and registers the selected word into a valid/ready output stage. It sits directly in front of the 6-bit mux instance and replaces any free-running select logic.

---
 rtl/six_bit_two_port_arbiter_pkg.sv | 32 +++
 rtl/six_bit_two_port_arbiter_mux.sv | 36 +++
 rtl/six_bit_two_port_arbiter.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/six_bit_two_port_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// six_bit_two_port_arbiter_pkg
//
// Shared definitions for the two-port arbiter in front of the 6-bit mux:
//   - arb_state_t      : FSM state encoding (IDLE / GRANT_A / GRANT_B)
//   - DEFAULT_DATA_WIDTH, DEFAULT_MAX_BURST : default parameter values
//   - is_grant()       : true in either grant state
// ----------------------------------------------------------------------------
package six_bit_two_port_arbiter_pkg;

    // Default word width; the mux instance is 6 bits wide.
    localparam int DEFAULT_DATA_WIDTH = 6;

    // Default maximum words accepted per grant. The burst counter is 4 bits,
    // so legal values are 1..15.
    localparam int DEFAULT_MAX_BURST = 4;

    // Burst counter width.
    localparam int CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_A = 2'd1,
        GRANT_B = 2'd2
    } arb_state_t;

    // True while one of the requesters owns the channel.
    function automatic logic is_grant(input arb_state_t s);
        return (s == GRANT_A) || (s == GRANT_B);
    endfunction

endpackage

// File: rtl/six_bit_two_port_arbiter_mux.sv
// ----------------------------------------------------------------------------
// six_bit_two_to_one_mux_gatelevel_module
//
// Gate-level two-to-one word mux: y = s ? b : a, built bit by bit from
// AND/OR/NOT primitives.
//
// Ports:
//   a  in  WIDTH  word selected when s = 0
//   b  in  WIDTH  word selected when s = 1
//   s  in  1      select
//   y  out WIDTH  selected word
// ----------------------------------------------------------------------------
module six_bit_two_to_one_mux_gatelevel_module #(
    parameter int WIDTH = 6
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             s,
    output logic [WIDTH-1:0] y
);

    wire             s_n;
    wire [WIDTH-1:0] a_term;
    wire [WIDTH-1:0] b_term;

    not u_inv (s_n, s);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            and u_and_a (a_term[gi], a[gi], s_n);
            and u_and_b (b_term[gi], b[gi], s);
            or  u_or    (y[gi], a_term[gi], b_term[gi]);
        end
    endgenerate

endmodule

// File: rtl/six_bit_two_port_arbiter.sv
// ----------------------------------------------------------------------------
// six_bit_two_port_arbiter
//
// Round-robin arbiter and sequencer for the shared 6-bit two-to-one mux.
// Two requesters compete for one output channel; the winner is granted for a
// burst of at most MAX_BURST words (or until it signals last / drops req),
// after which priority flips to the other requester. The selected word is
// registered into a valid/ready output stage.
//
// Ports:
//   clk        in   1           rising-edge clock
//   reset_n    in   1           asynchronous active-low reset
//   req_a      in   1           requester A presents a word on data_a
//   data_a     in   DATA_WIDTH  requester A word
//   last_a     in   1           current A word ends A's burst
//   ack_a      out  1           A word accepted this cycle (combinational)
//   req_b      in   1           requester B presents a word on data_b
//   data_b     in   DATA_WIDTH  requester B word
//   last_b     in   1           current B word ends B's burst
//   ack_b      out  1           B word accepted this cycle (combinational)
//   out_valid  out  1           out_data holds a word
//   out_data   out  DATA_WIDTH  registered output word
//   out_ready  in   1           downstream accepts out_data this cycle
//   grant_b    out  1           registered mux select (0 = A, 1 = B)
//   busy       out  1           high in either grant state
// ----------------------------------------------------------------------------
module six_bit_two_port_arbiter
    import six_bit_two_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int MAX_BURST  = DEFAULT_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  req_a,
    input  logic [DATA_WIDTH-1:0] data_a,
    input  logic                  last_a,
    output logic                  ack_a,

    input  logic                  req_b,
    input  logic [DATA_WIDTH-1:0] data_b,
    input  logic                  last_b,
    output logic                  ack_b,

    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,

    output logic                  grant_b,
    output logic                  busy
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    arb_state_t             state_reg;
    arb_state_t             state_next;
    logic                   prio_reg;       // 0 = A favoured, 1 = B favoured
    logic [CNT_WIDTH-1:0]   cnt_reg;        // words accepted in current grant
    logic                   out_valid_reg;
    logic [DATA_WIDTH-1:0]  out_data_reg;
    logic                   grant_b_reg;
    logic                   grant_b_next;

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic                   space;          // output stage can take a word
    logic                   accept;         // a word is taken this cycle
    logic                   cur_req;        // req of the granted requester
    logic                   cur_last;       // last of the granted requester
    logic                   other_req;      // req of the other requester
    logic                   burst_full;     // this accept is the MAX_BURST-th
    logic                   release_grant;  // grant ends this cycle
    logic [CNT_WIDTH-1:0]   cnt_plus_one;
    logic [DATA_WIDTH-1:0]  mux_y;

    // An accept and a drain can happen in the same cycle, giving one word per
    // cycle while out_ready stays high.
    assign space        = !out_valid_reg || out_ready;
    assign cnt_plus_one = cnt_reg + CNT_WIDTH'(1);
    assign burst_full   = (cnt_plus_one == CNT_WIDTH'(MAX_BURST));

    // ------------------------------------------------------------------
    // Mux datapath: grant_b is registered and always matches the grant
    // state, so in a grant state the mux already presents the owner's word.
    // ------------------------------------------------------------------
    six_bit_two_to_one_mux_gatelevel_module #(
        .WIDTH (DATA_WIDTH)
    ) u_mux (
        .a (data_a),
        .b (data_b),
        .s (grant_b_reg),
        .y (mux_y)
    );

    // ------------------------------------------------------------------
    // FSM process 1: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM process 2: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (req_a && req_b) begin
                    state_next = prio_reg ? GRANT_B : GRANT_A;
                end else if (req_a) begin
                    state_next = GRANT_A;
                end else if (req_b) begin
                    state_next = GRANT_B;
                end
            end
            GRANT_A: begin
                // Handover goes straight to the other requester without a
                // dead IDLE cycle when it is already waiting.
                if (release_grant) begin
                    state_next = other_req ? GRANT_B : IDLE;
                end
            end
            GRANT_B: begin
                if (release_grant) begin
                    state_next = other_req ? GRANT_A : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM process 3: outputs and per-cycle control decode
    // ------------------------------------------------------------------
    always_comb begin
        ack_a         = 1'b0;
        ack_b         = 1'b0;
        cur_req       = 1'b0;
        cur_last      = 1'b0;
        other_req     = 1'b0;
        release_grant = 1'b0;
        busy          = is_grant(state_reg);

        case (state_reg)
            GRANT_A: begin
                ack_a     = req_a && space;
                cur_req   = req_a;
                cur_last  = last_a;
                other_req = req_b;
            end
            GRANT_B: begin
                ack_b     = req_b && space;
                cur_req   = req_b;
                cur_last  = last_b;
                other_req = req_a;
            end
            default: ;
        endcase

        accept = ack_a || ack_b;

        // A stalled requester (req high, no space) keeps its grant; dropping
        // req ends the grant immediately without an accept.
        if (is_grant(state_reg)) begin
            release_grant = (accept && (cur_last || burst_full)) || !cur_req;
        end
    end

    // ------------------------------------------------------------------
    // Mux select: follows the grant state, holds its value through IDLE so
    // the mux does not toggle needlessly.
    // ------------------------------------------------------------------
    always_comb begin
        grant_b_next = grant_b_reg;
        if (state_next == GRANT_B) begin
            grant_b_next = 1'b1;
        end else if (state_next == GRANT_A) begin
            grant_b_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Priority pointer and burst counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prio_reg <= 1'b0;
            cnt_reg  <= '0;
        end else if (release_grant) begin
            // Favour whoever did not just own the channel.
            prio_reg <= (state_reg == GRANT_A);
            cnt_reg  <= '0;
        end else if (accept) begin
            cnt_reg  <= cnt_plus_one;
        end
    end

    // ------------------------------------------------------------------
    // Output stage and registered select
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            grant_b_reg   <= 1'b0;
        end else begin
            grant_b_reg <= grant_b_next;
            if (accept) begin
                out_valid_reg <= 1'b1;
                out_data_reg  <= mux_y;
            end else if (out_ready) begin
                // Drain: data holds its value, only valid drops.
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign grant_b   = grant_b_reg;

endmodule
